// File: rtl/ext_skid_buf_if.sv
// Handshake bundle for ext_skid_buf: narrow field in, extended word out.
// Carries flush, occupancy and both valid/ready pairs.
interface ext_skid_buf_if #(
  parameter int IN_W  = 1,
  parameter int OUT_W = 32
);
  logic [IN_W-1:0]  I;
  logic             SEXT;
  logic             I_VALID;
  logic             I_READY;
  logic             FLUSH;
  logic [OUT_W-1:0] O;
  logic             O_VALID;
  logic             O_READY;
  logic [1:0]       COUNT;

  modport master (
    output I, SEXT, I_VALID,
    output FLUSH, O_READY,
    input  I_READY, O, O_VALID,
    input  COUNT
  );

  modport slave (
    input  I, SEXT, I_VALID,
    input  FLUSH, O_READY,
    output I_READY, O, O_VALID,
    output COUNT
  );
endinterface

// File: rtl/ext_skid_buf.sv
// Registered width extender with a two-entry skid buffer.
// EXT_SIGN_EN builds sign extension; otherwise every capture zero-extends.
module ext_skid_buf #(
  parameter int IN_W  = 1,
  parameter int OUT_W = 32
) (
  input  logic          CLK,
  input  logic          RST,
  ext_skid_buf_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] head_q, head_d;
  logic [OUT_W-1:0] skid_q, skid_d;
  logic [OUT_W-1:0] ext_w;
  logic             i_ready;
  logic             o_valid;
  logic             in_fire;
  logic             out_fire;
  logic             unused_sext;

  assign unused_sext = bus.SEXT;

  generate
    if (OUT_W == IN_W) begin : g_same
      assign ext_w = bus.I;
    end else begin : g_wide
      logic fill;
`ifdef EXT_SIGN_EN
      assign fill = bus.SEXT & bus.I[IN_W-1];
`else
      assign fill = 1'b0;
`endif
      assign ext_w = {{(OUT_W-IN_W){fill}}, bus.I};
    end
  endgenerate

  // Ready never looks at O_READY, so no comb path crosses the buffer.
  assign i_ready  = !RST && !bus.FLUSH && (state_q != TWO);
  assign o_valid  = (state_q != EMPTY);
  assign in_fire  = bus.I_VALID && i_ready;
  assign out_fire = o_valid && bus.O_READY;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.FLUSH) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            head_d  = ext_w;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            skid_d  = ext_w;
            state_d = TWO;
          end else if (in_fire && out_fire) begin
            head_d  = ext_w;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.I_READY = i_ready;
  assign bus.O_VALID = o_valid;
  assign bus.O       = head_q;
  assign bus.COUNT   = state_q;
endmodule

// File: tb/tb_ext_skid_buf.sv
// Random and directed bench for ext_skid_buf (IN_W=4, OUT_W=32).
// Reference is a bounded queue of extended words plus last-output tracking.
module tb_ext_skid_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ext_skid_buf_if #(.IN_W(4), .OUT_W(32)) bus ();

  ext_skid_buf #(.IN_W(4), .OUT_W(32)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq[$];
  logic [31:0] obs_q[$];
  logic [31:0] last_o = '0;
  logic        last_in_fire;

`ifdef EXT_SIGN_EN
  bit use_sign = 1'b1;
`else
  bit use_sign = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_ext(input logic [3:0] v,
                                        input logic s);
    int n;
    n = int'(v);
    if (use_sign && s && n >= 8) n = n - 16;
    return 32'(n);
  endfunction

  task automatic check_state(input logic fl);
    logic [31:0] exp_o;
    exp_o = (mq.size() > 0) ? mq[0] : last_o;
    chk("i_ready", 32'(bus.I_READY),
        32'(!fl && mq.size() < 2));
    chk("o_valid", 32'(bus.O_VALID), 32'(mq.size() > 0));
    chk("count", 32'(bus.COUNT), 32'(mq.size()));
    chk("o", bus.O, exp_o);
  endtask

  // One clock: drive, check at negedge, advance model at posedge.
  task automatic cycle(input logic iv, input logic [3:0] d,
                       input logic s, input logic ordy,
                       input logic fl);
    logic inf, outf;
    bus.I_VALID = iv;
    bus.I       = d;
    bus.SEXT    = s;
    bus.O_READY = ordy;
    bus.FLUSH   = fl;
    @(negedge clk);
    check_state(fl);
    inf  = iv && !fl && mq.size() < 2;
    outf = ordy && mq.size() > 0;
    if (bus.O_VALID && ordy) obs_q.push_back(bus.O);
    @(posedge clk);
    if (outf) last_o = mq.pop_front();
    if (fl) begin
      mq.delete();
      last_o = '0;
    end else if (inf) begin
      mq.push_back(m_ext(d, s));
    end
    last_in_fire = inf;
    #1;
  endtask

  initial begin
    logic [3:0] d;
    logic       s, iv, pend;
    bus.I = '0; bus.SEXT = 1'b0; bus.I_VALID = 1'b0;
    bus.O_READY = 1'b0; bus.FLUSH = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.I_READY), 32'd0);
    chk("rst_valid", 32'(bus.O_VALID), 32'd0);
    chk("rst_count", 32'(bus.COUNT), 32'd0);
    chk("rst_o", bus.O, 32'd0);
    rst = 1'b0;

    cycle(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    chk("zext_1", bus.O, 32'h00000001);
    chk("zext_v", 32'(bus.O_VALID), 32'd1);
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    cycle(1'b1, 4'hA, 1'b1, 1'b1, 1'b0);
    chk("sext_a", bus.O, use_sign ? 32'hFFFFFFFA : 32'h0000000A);
    cycle(1'b1, 4'h5, 1'b1, 1'b1, 1'b0);
    chk("sext_5", bus.O, 32'h00000005);
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    obs_q.delete();
    cycle(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    chk("bp_count", 32'(bus.COUNT), 32'd2);
    chk("bp_ready", 32'(bus.I_READY), 32'd0);
    chk("bp_held", 32'(last_in_fire), 32'd0);
    pend = 1'b1;
    while (pend) begin
      cycle(1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
      pend = !last_in_fire;
    end
    repeat (3) cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("bp_n", 32'(obs_q.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < obs_q.size())
        chk("bp_ord", obs_q[k], 32'(k + 1));

    obs_q.delete();
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 4'(k), 1'b0, 1'b1, 1'b0);
      chk("st_fire", 32'(last_in_fire), 32'd1);
    end
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("st_n", 32'(obs_q.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      if (k < obs_q.size())
        chk("st_ord", obs_q[k], 32'(k));

    cycle(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    chk("fl_pre", 32'(bus.COUNT), 32'd2);
    cycle(1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
    chk("fl_cap", 32'(last_in_fire), 32'd0);
    chk("fl_count", 32'(bus.COUNT), 32'd0);
    chk("fl_valid", 32'(bus.O_VALID), 32'd0);
    chk("fl_o", bus.O, 32'd0);

    cycle(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_o", bus.O, 32'd0);
    chk("ar_valid", 32'(bus.O_VALID), 32'd0);
    chk("ar_count", 32'(bus.COUNT), 32'd0);
    chk("ar_ready", 32'(bus.I_READY), 32'd0);
    mq.delete();
    last_o = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    pend = 1'b0;
    d = '0; s = 1'b0; iv = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend) begin
        iv = ($urandom_range(0, 3) != 0);
        d  = 4'($urandom);
        s  = 1'($urandom);
      end
      cycle(iv, d, s, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 39) == 0));
      pend = iv && !last_in_fire;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ext_skid_buf.md
# ext_skid_buf

Registered, parametrised width extender with a two-entry valid/ready skid buffer. It takes an IN_W-bit field and presents it zero- or sign-extended to OUT_W bits. It sits between pipeline stages of the DLX datapath wherever a narrow flag, immediate or nibble must be widened to a full register word. It sustains one transfer per cycle under backpressure without a combinational ready path from output to input.

## Interface
Parameters:
- IN_W, default 1: input field width; must satisfy 1 <= IN_W <= OUT_W.
- OUT_W, default 32: output word width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- I  in  IN_W  input field.
- SEXT  in  1  extension mode, sampled with I: 0 = zero-extend, 1 = sign-extend.
- I_VALID  in  1  upstream has data on I and SEXT.
- I_READY  out  1  block accepts I this cycle.
- FLUSH  in  1  synchronous discard of all buffered entries.
- O  out  OUT_W  extended word, head entry.
- O_VALID  out  1  O holds a valid entry.
- O_READY  in  1  downstream accepts O this cycle.
- COUNT  out  2  occupancy: 0, 1 or 2.

## Operation
- in_fire = I_VALID & I_READY; out_fire = O_VALID & O_READY.
- Extension is applied at capture:
  - Zero mode: ext(I) = {(OUT_W-IN_W) zeros, I}.
  - Sign mode: ext(I) = {(OUT_W-IN_W) copies of I[IN_W-1], I}.
  - IN_W == OUT_W: ext(I) = I, and SEXT has no effect.
- Storage is a head register (drives O) and a skid register. The state is COUNT.
- EMPTY (0):
  - in_fire: head <= ext(I); go to ONE.
- ONE (1):
  - in_fire & !out_fire: skid <= ext(I); go to TWO.
  - in_fire & out_fire: head <= ext(I); stay in ONE.
  - out_fire only: go to EMPTY.
- TWO (2):
  - out_fire: head <= skid; go to ONE.
  - No input is accepted in TWO.
- O_VALID = (COUNT != 0).
- I_READY = !RST & !FLUSH & (COUNT != 2). This depends only on state, FLUSH and RST, never on O_READY.
- FLUSH has priority over all transfers:
  - Next state is EMPTY; head and skid are cleared to 0.
  - An out_fire in the same cycle still counts as delivered.
  - Input is refused, because I_READY is low.
- Data order is strict FIFO. No entry is duplicated or dropped except by FLUSH or RST.

## Timing
- Reset values: O = 0, O_VALID = 0, COUNT = 0, skid = 0, I_READY = 0 while RST is high.
- In the first cycle after RST deasserts, I_READY = 1.
- RST asserted mid-operation clears state immediately (asynchronously). Entries in flight are lost.
- Latency: data accepted at edge N appears on O with O_VALID = 1 after edge N; O is valid in the cycle following acceptance.
- Throughput: one word per cycle while O_READY = 1. COUNT stays at 1 under continuous streaming.
- While O_VALID & !O_READY, O and O_VALID are held stable.
- When empty, O holds its last value. O is meaningful only when O_VALID = 1.
- Upstream must hold I, SEXT and I_VALID stable until in_fire.

## Configuration
- EXT_SIGN_EN defined: SEXT selects zero or sign extension as described above.
- EXT_SIGN_EN undefined:
  - Sign-extension logic is not built and SEXT is ignored.
  - Every capture is a zero extension, matching the legacy zero-buffer behaviour.

## Test plan
- Reset: assert RST with COUNT = 2 mid-stream -> O = 0, O_VALID = 0, COUNT = 0, I_READY = 0 immediately; after release, I_READY = 1 on the next cycle.
- Zero-extend (IN_W=1, OUT_W=32): I = 1, SEXT = 0 accepted -> next cycle O = 32'h00000001, O_VALID = 1.
- Sign-extend (IN_W=4, OUT_W=32, EXT_SIGN_EN):
  - I = 4'hA, SEXT = 1 -> O = 32'hFFFFFFFA.
  - I = 4'h5, SEXT = 1 -> O = 32'h00000005.
  - Without EXT_SIGN_EN, I = 4'hA with SEXT = 1 -> O = 32'h0000000A.
- Backpressure (IN_W=4), O_READY = 0, offer 1, 2, 3 -> 1 and 2 accepted, COUNT = 2, I_READY = 0, 3 held upstream. Raise O_READY -> outputs 1, 2, 3 in order, no loss.
- Streaming: O_READY = 1, I_VALID high for 16 cycles with values 0..15 -> 16 consecutive outputs 0..15, COUNT = 1 throughout, I_READY never drops.
- Flush: at COUNT = 2, pulse FLUSH with I_VALID = 1 -> I_READY = 0 that cycle; next cycle COUNT = 0, O_VALID = 0, O = 0, and the offered word is not captured.
